instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 144 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Loads instructions into instruction memory from board switches. A Start
//   edge opens a session at address 0; each word is entered as two Load_Strobe
//   edges (low half-word first, then high half-word) and then written through a
//   req/ack handshake. After the last address, or on a Finish edge, the block
//   parks in DONE.
// Ports
//   i_clock, i_reset_l      : clock, asynchronous active-low reset
//   i_data_in[15:0]         : half-word from the switches
//   i_load_strobe           : debounced button level (rising edge latches data)
//   i_start / i_finish      : session begin / early end (rising edges)
//   i_mem_ack               : memory write acknowledge
//   o_mem_req               : write request, held until acknowledged
//   o_mem_address           : word address being written
//   o_mem_write_data[31:0]  : assembled instruction word
//   o_loader_busy           : loader owns the memory port
//   o_load_done             : session finished
//   o_status_display[31:0]  : {address zero-extended, last half-word}
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset_l,
  input  logic [15:0]           i_data_in,
  input  logic                  i_load_strobe,
  input  logic                  i_start,
  input  logic                  i_finish,
  input  logic                  i_mem_ack,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [31:0]           o_mem_write_data,
  output logic                  o_loader_busy,
  output logic                  o_load_done,
  output logic [31:0]           o_status_display
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE, LOW_HALF, HIGH_HALF, WRITE, DONE
  } state_t;

  // Edge detection on {finish, start, strobe}. r_arm only sets once an input
  // has been seen low after reset, so a level already high at reset release
  // never counts as an edge.
  logic [2:0] w_in, r_cur, r_prev, r_arm, w_edge;
  logic       w_strobe_e, w_start_e, w_finish_e;

  assign w_in       = {i_finish, i_start, i_load_strobe};
  assign w_edge     = r_cur & ~r_prev & r_arm;
  assign w_strobe_e = w_edge[0];
  assign w_start_e  = w_edge[1];
  assign w_finish_e = w_edge[2];

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_cur  <= '0;
      r_prev <= '0;
      r_arm  <= '0;
    end else begin
      r_cur  <= w_in;
      r_prev <= r_cur;
      r_arm  <= r_arm | ~w_in;
    end
  end

  state_t                r_state;
  logic                  r_req, r_busy, r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [15:0]           r_half;

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_half  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // Start wins over a coincident Finish here.
          if (w_start_e) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= LOW_HALF;
          end
        end
        LOW_HALF: begin
          // Finish wins over a coincident strobe.
          if (w_finish_e) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_strobe_e) begin
            r_wdata[15:0] <= i_data_in;
            r_half        <= i_data_in;
            r_state       <= HIGH_HALF;
          end
        end
        HIGH_HALF: begin
          // Finish here abandons the staged low half: nothing is written.
          if (w_finish_e) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_strobe_e) begin
            r_wdata[31:16] <= i_data_in;
            r_half         <= i_data_in;
            r_req          <= 1'b1;
            r_state        <= WRITE;
          end
        end
        WRITE: begin
          // Strobe/Finish edges are dropped here; only the ack moves us on.
          if (i_mem_ack) begin
            r_req <= 1'b0;
            if (r_addr == LAST_ADDR) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= LOW_HALF;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_req        = r_req;
  assign o_mem_address    = r_addr;
  assign o_mem_write_data = r_wdata;
  assign o_loader_busy    = r_busy;
  assign o_load_done      = r_done;
  assign o_status_display = {16'(r_addr), r_half};

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        strobe, start, finish, ack;

  logic        req_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a, stat_a;

  logic        req_b, busy_b, done_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b, stat_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(8)) dut_a (
    .i_clock(clk), .i_reset_l(rst_n), .i_data_in(din), .i_load_strobe(strobe),
    .i_start(start), .i_finish(finish), .i_mem_ack(ack),
    .o_mem_req(req_a), .o_mem_address(addr_a), .o_mem_write_data(wd_a),
    .o_loader_busy(busy_a), .o_load_done(done_a), .o_status_display(stat_a)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) dut_b (
    .i_clock(clk), .i_reset_l(rst_n), .i_data_in(din), .i_load_strobe(strobe),
    .i_start(start), .i_finish(finish), .i_mem_ack(ack),
    .o_mem_req(req_b), .o_mem_address(addr_b), .o_mem_write_data(wd_b),
    .o_loader_busy(busy_b), .o_load_done(done_b), .o_status_display(stat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Each pulse helper returns on the negedge after the FSM has acted on it.
  task automatic pulse_strobe(input logic [15:0] d);
    din = d; strobe = 1'b1; tick(); strobe = 1'b0; tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0; tick();
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  task automatic load_word(input logic [15:0] lo, input logic [15:0] hi, input string tag);
    pulse_strobe(lo);
    pulse_strobe(hi);
    chk({tag, "_req"}, {31'd0, req_a}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, req_a}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; strobe = 0; start = 0; finish = 0; ack = 0;
    #12;
    chk("rst_req",  {31'd0, req_a}, 32'd0);
    chk("rst_addr", {24'd0, addr_a}, 32'd0);
    chk("rst_wd",   wd_a, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_stat", stat_a, 32'd0);
    tick(); rst_n = 1'b1; tick();

    // Single word with ack after three request cycles
    pulse_start();
    chk("s1_busy", {31'd0, busy_a}, 32'd1);
    chk("s1_addr", {24'd0, addr_a}, 32'd0);
    pulse_strobe(16'h1234);
    chk("s1_stat_lo", stat_a, 32'h0000_1234);
    chk("s1_req_low", {31'd0, req_a}, 32'd0);
    pulse_strobe(16'hABCD);
    chk("s1_req_c1", {31'd0, req_a}, 32'd1);
    chk("s1_wd", wd_a, 32'hABCD_1234);
    chk("s1_waddr", {24'd0, addr_a}, 32'd0);
    chk("s1_stat_hi", stat_a, 32'h0000_ABCD);
    tick();
    chk("s1_req_c2", {31'd0, req_a}, 32'd1);
    tick();
    chk("s1_req_c3", {31'd0, req_a}, 32'd1);
    chk("s1_wd_hold", wd_a, 32'hABCD_1234);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("s1_req_off", {31'd0, req_a}, 32'd0);
    chk("s1_addr1", {24'd0, addr_a}, 32'd1);
    chk("s1_busy_low", {31'd0, busy_a}, 32'd1);

    // Two more words, then Finish in LOW_HALF
    load_word(16'h1111, 16'h2222, "w2");
    load_word(16'h3333, 16'h4444, "w3");
    chk("w3_wd", wd_a, 32'h4444_3333);
    pulse_finish();
    chk("fin_done", {31'd0, done_a}, 32'd1);
    chk("fin_busy", {31'd0, busy_a}, 32'd0);
    chk("fin_stat", stat_a, 32'h0003_4444);

    // Restart from DONE, abandon a staged low half
    pulse_start();
    chk("rs_addr", {24'd0, addr_a}, 32'd0);
    chk("rs_done", {31'd0, done_a}, 32'd0);
    pulse_strobe(16'h00FF);
    chk("ab_stat", stat_a, 32'h0000_00FF);
    pulse_finish();
    chk("ab_done", {31'd0, done_a}, 32'd1);
    chk("ab_req", {31'd0, req_a}, 32'd0);
    tick(); tick();
    chk("ab_req2", {31'd0, req_a}, 32'd0);
    pulse_start();
    chk("rs2_addr", {24'd0, addr_a}, 32'd0);
    chk("rs2_busy", {31'd0, busy_a}, 32'd1);

    // Strobe/Finish during WRITE ignored; ack held in LOW_HALF ignored
    pulse_strobe(16'h5A5A);
    pulse_strobe(16'hC3C3);
    chk("iw_req", {31'd0, req_a}, 32'd1);
    din = 16'h5555; strobe = 1'b1; finish = 1'b1; tick();
    strobe = 1'b0; finish = 1'b0; tick(); tick();
    chk("iw_req_hold", {31'd0, req_a}, 32'd1);
    chk("iw_wd_hold", wd_a, 32'hC3C3_5A5A);
    chk("iw_stat_hold", stat_a, 32'h0000_C3C3);
    ack = 1'b1; tick();
    chk("iw_addr1", {24'd0, addr_a}, 32'd1);
    tick(); tick(); tick();
    ack = 1'b0;
    chk("ia_addr", {24'd0, addr_a}, 32'd1);
    chk("ia_req", {31'd0, req_a}, 32'd0);
    chk("ia_busy", {31'd0, busy_a}, 32'd1);
    chk("ia_stat", stat_a, 32'h0001_C3C3);
    // Coincident strobe + Finish in LOW_HALF acts as Finish
    din = 16'h7777; strobe = 1'b1; finish = 1'b1; tick();
    strobe = 1'b0; finish = 1'b0; tick();
    chk("sf_done", {31'd0, done_a}, 32'd1);
    chk("sf_stat", stat_a, 32'h0001_C3C3);

    // ADDR_WIDTH=2 instance: fill all four words
    do_reset();
    pulse_start();
    load_word(16'h0001, 16'h1000, "b0");
    load_word(16'h0002, 16'h2000, "b1");
    load_word(16'h0003, 16'h3000, "b2");
    chk("b_addr3", {30'd0, addr_b}, 32'd3);
    chk("b_busy3", {31'd0, busy_b}, 32'd1);
    load_word(16'h0004, 16'h4000, "b3");
    chk("b_done", {31'd0, done_b}, 32'd1);
    chk("b_addr_hold", {30'd0, addr_b}, 32'd3);
    chk("b_busy_end", {31'd0, busy_b}, 32'd0);
    chk("b_wd", wd_b, 32'h4000_0004);
    pulse_strobe(16'h9999);
    pulse_strobe(16'h8888);
    tick();
    chk("b_no_req", {31'd0, req_b}, 32'd0);
    chk("b_stat", stat_b, 32'h0003_4000);

    // Reset mid-WRITE, then release with Start held high
    do_reset();
    pulse_start();
    pulse_strobe(16'hBEEF);
    pulse_strobe(16'hDEAD);
    chk("rw_req", {31'd0, req_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req0", {31'd0, req_a}, 32'd0);
    chk("rw_addr0", {24'd0, addr_a}, 32'd0);
    chk("rw_wd0", wd_a, 32'd0);
    chk("rw_busy0", {31'd0, busy_a}, 32'd0);
    chk("rw_stat0", stat_a, 32'd0);
    tick(); start = 1'b1; tick(); rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rh_busy", {31'd0, busy_a}, 32'd0);
    chk("rh_done", {31'd0, done_a}, 32'd0);
    // Coincident Start + Finish in IDLE acts as Start
    start = 1'b0; tick();
    start = 1'b1; finish = 1'b1; tick();
    start = 1'b0; finish = 1'b0; tick();
    chk("sf2_busy", {31'd0, busy_a}, 32'd1);
    chk("sf2_done", {31'd0, done_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
